// File: rtl/mem_burst_arbiter.sv
// Two-client round-robin arbiter in front of a single burst-level AXI master port.
// Grants one read or write burst at a time and routes strobes/finish to the owner only.
module mem_burst_arbiter #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 32,
    parameter int LEN_BITS      = 10
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,

    input  logic                     c0_wr_burst_req,
    input  logic                     c0_rd_burst_req,
    input  logic [ADDR_BITS-1:0]     c0_wr_burst_addr,
    input  logic [ADDR_BITS-1:0]     c0_rd_burst_addr,
    input  logic [LEN_BITS-1:0]      c0_wr_burst_len,
    input  logic [LEN_BITS-1:0]      c0_rd_burst_len,
    input  logic [MEM_DATA_BITS-1:0] c0_wr_burst_data,
    output logic                     c0_wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] c0_rd_burst_data,
    output logic                     c0_rd_burst_data_valid,
    output logic                     c0_wr_burst_finish,
    output logic                     c0_rd_burst_finish,

    input  logic                     c1_wr_burst_req,
    input  logic                     c1_rd_burst_req,
    input  logic [ADDR_BITS-1:0]     c1_wr_burst_addr,
    input  logic [ADDR_BITS-1:0]     c1_rd_burst_addr,
    input  logic [LEN_BITS-1:0]      c1_wr_burst_len,
    input  logic [LEN_BITS-1:0]      c1_rd_burst_len,
    input  logic [MEM_DATA_BITS-1:0] c1_wr_burst_data,
    output logic                     c1_wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] c1_rd_burst_data,
    output logic                     c1_rd_burst_data_valid,
    output logic                     c1_wr_burst_finish,
    output logic                     c1_rd_burst_finish,

    output logic                     m_wr_burst_req,
    output logic                     m_rd_burst_req,
    output logic [ADDR_BITS-1:0]     m_wr_burst_addr,
    output logic [ADDR_BITS-1:0]     m_rd_burst_addr,
    output logic [LEN_BITS-1:0]      m_wr_burst_len,
    output logic [LEN_BITS-1:0]      m_rd_burst_len,
    output logic [MEM_DATA_BITS-1:0] m_wr_burst_data,
    input  logic                     m_wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] m_rd_burst_data,
    input  logic                     m_rd_burst_data_valid,
    input  logic                     m_wr_burst_finish,
    input  logic                     m_rd_burst_finish,

    output logic                     busy,
    output logic [1:0]               owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [1:0] ptr;
    logic [1:0] owner_q;
    logic [3:0] req_vec;
    logic       grant_found;
    logic [1:0] grant_idx;
    logic       finish_hit;
    logic       in_busy;
    logic       wr_req_q, rd_req_q;

    // Source index: 0 = c0 write, 1 = c0 read, 2 = c1 write, 3 = c1 read.
    assign req_vec = {c1_rd_burst_req, c1_wr_burst_req, c0_rd_burst_req, c0_wr_burst_req};

    always_comb begin
        logic [1:0] idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!grant_found && req_vec[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    assign finish_hit = owner_q[0] ? m_rd_burst_finish : m_wr_burst_finish;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (grant_found) state_n = BUSY;
            BUSY:    if (finish_hit)  state_n = GAP;
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ptr             <= '0;
            owner_q         <= '0;
            wr_req_q        <= 1'b0;
            rd_req_q        <= 1'b0;
            m_wr_burst_addr <= '0;
            m_rd_burst_addr <= '0;
            m_wr_burst_len  <= '0;
            m_rd_burst_len  <= '0;
        end else if (state == IDLE && grant_found) begin
            owner_q  <= grant_idx;
            ptr      <= grant_idx + 2'd1;
            wr_req_q <= !grant_idx[0];
            rd_req_q <= grant_idx[0];
            if (grant_idx[0]) begin
                m_rd_burst_addr <= grant_idx[1] ? c1_rd_burst_addr : c0_rd_burst_addr;
                m_rd_burst_len  <= grant_idx[1] ? c1_rd_burst_len  : c0_rd_burst_len;
            end else begin
                m_wr_burst_addr <= grant_idx[1] ? c1_wr_burst_addr : c0_wr_burst_addr;
                m_wr_burst_len  <= grant_idx[1] ? c1_wr_burst_len  : c0_wr_burst_len;
            end
        end else if (state == BUSY && finish_hit) begin
            wr_req_q <= 1'b0;
            rd_req_q <= 1'b0;
        end
    end

    assign m_wr_burst_req = wr_req_q;
    assign m_rd_burst_req = rd_req_q;
    assign owner          = owner_q;
    assign busy           = (state != IDLE);
    assign in_busy        = (state == BUSY);

    // Strobes and data only pass while BUSY; everything else sees zero.
    assign m_wr_burst_data        = in_busy ? (owner_q[1] ? c1_wr_burst_data : c0_wr_burst_data) : '0;
    assign c0_rd_burst_data       = in_busy ? m_rd_burst_data : '0;
    assign c1_rd_burst_data       = in_busy ? m_rd_burst_data : '0;

    assign c0_wr_burst_data_req   = in_busy && owner_q == 2'd0 && m_wr_burst_data_req;
    assign c0_rd_burst_data_valid = in_busy && owner_q == 2'd1 && m_rd_burst_data_valid;
    assign c1_wr_burst_data_req   = in_busy && owner_q == 2'd2 && m_wr_burst_data_req;
    assign c1_rd_burst_data_valid = in_busy && owner_q == 2'd3 && m_rd_burst_data_valid;

    assign c0_wr_burst_finish     = in_busy && owner_q == 2'd0 && m_wr_burst_finish;
    assign c0_rd_burst_finish     = in_busy && owner_q == 2'd1 && m_rd_burst_finish;
    assign c1_wr_burst_finish     = in_busy && owner_q == 2'd2 && m_wr_burst_finish;
    assign c1_rd_burst_finish     = in_busy && owner_q == 2'd3 && m_rd_burst_finish;

endmodule
